// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported data
//               memory: one access per grant, loads answered one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_sel;
    logic              r_we;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_start;
    logic              w_pick1;

    // r_last = 1 means port 1 was served most recently, so port 0 wins a tie.
    always_comb begin
        w_start = 1'b0;
        w_pick1 = 1'b0;
        if (r_state == IDLE) begin
            w_start = req0 | req1;
            w_pick1 = req1 & (~req0 | ~r_last);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_sel   <= w_pick1;
                r_we    <= w_pick1 ? we1 : we0;
                r_addr  <= w_pick1 ? addr1 : addr0;
                r_wdata <= w_pick1 ? wdata1 : wdata0;
            end
            if (r_state == ACCESS) begin
                r_last <= r_sel;
                if (!r_we) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        rvalid0      = 1'b0;
        rvalid1      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                gnt0         = ~r_sel;
                gnt1         = r_sel;
                mem_read     = ~r_we;
                mem_write    = r_we;
                w_next_state = r_we ? IDLE : RESP;
            end
            RESP: begin
                rvalid0      = ~r_sel;
                rvalid1      = r_sel;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a transaction-level
//               reference of the arbitration rules and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 773 + 4369);
    endfunction

    // Environment memory behind the arbiter.
    logic [DATA_W-1:0] mem [0:63];
    assign mem_rdata = mem[mem_addr];
    initial for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not match expectation at t=%0t", name, $time);
    endtask

    typedef struct {int port; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; int cyc;} gexp_t;
    typedef struct {int port; logic [DATA_W-1:0] data; int cyc;} rexp_t;
    typedef struct {int port; int cyc;} glog_t;

    gexp_t exp_q[$];
    rexp_t rv_q[$];
    glog_t gnt_log[$];

    // Reference: one transaction at a time, store occupies 1 cycle after the
    // sampling edge, load occupies 2; ties go to the port not served last.
    int                cyc = 0;
    int                m_wait = 0;
    int                m_last = 1;
    logic [DATA_W-1:0] ref_mem [0:63];
    bit                pend_st = 0;
    logic [ADDR_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_d;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_wait  = 0;
                m_last  = 1;
                pend_st = 0;
                exp_q.delete();
                rv_q.delete();
            end else begin : model_step
                int    w;
                gexp_t g;
                if (pend_st) begin
                    ref_mem[pend_a] = pend_d;
                    pend_st = 0;
                end
                if (m_wait > 0) begin
                    m_wait--;
                end else if (req0 || req1) begin
                    w       = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                    g.port  = w;
                    g.we    = (w == 1) ? we1 : we0;
                    g.addr  = (w == 1) ? addr1 : addr0;
                    g.wdata = (w == 1) ? wdata1 : wdata0;
                    g.cyc   = cyc + 1;
                    exp_q.push_back(g);
                    if (g.we) begin
                        pend_st = 1;
                        pend_a  = g.addr;
                        pend_d  = g.wdata;
                        m_wait  = 1;
                    end else begin
                        rv_q.push_back(rexp_t'{w, ref_mem[g.addr], cyc + 2});
                        m_wait = 2;
                    end
                    m_last = w;
                end
                cyc++;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    gexp_t mon_g;
    rexp_t mon_r;
    int    mon_p;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                note_fail("gnt_missing");
                void'(exp_q.pop_front());
            end
            while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
                note_fail("rvalid_missing");
                void'(rv_q.pop_front());
            end
            if (gnt0 || gnt1) begin
                mon_p = gnt1 ? 1 : 0;
                gnt_log.push_back(glog_t'{mon_p, cyc});
                chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
                if (exp_q.size() == 0) begin
                    note_fail("gnt_unexpected");
                end else begin
                    mon_g = exp_q.pop_front();
                    chk("gnt_port", 32'(mon_p), 32'(mon_g.port));
                    chk("gnt_cycle", 32'(cyc), 32'(mon_g.cyc));
                    chk("mem_addr", 32'(mem_addr), 32'(mon_g.addr));
                    chk("mem_write", 32'(mem_write), 32'(mon_g.we));
                    chk("mem_read", 32'(mem_read), 32'(!mon_g.we));
                    if (mon_g.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_g.wdata));
                end
            end else begin
                chk("mem_idle", 32'({mem_read, mem_write}), 32'd0);
            end
            if (rvalid0 || rvalid1) begin
                mon_p = rvalid1 ? 1 : 0;
                chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
                if (rv_q.size() == 0) begin
                    note_fail("rvalid_unexpected");
                end else begin
                    mon_r = rv_q.pop_front();
                    chk("rvalid_port", 32'(mon_p), 32'(mon_r.port));
                    chk("rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
                    chk("rdata", 32'(rdata), 32'(mon_r.data));
                end
            end
            chk("busy", 32'(busy), 32'(m_wait != 0));
        end
    end

    // Requester: raise at a negedge, hold until its gnt, then drop.
    task automatic drive(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int gap);
        bit got;
        got = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if ((p == 0 && gnt0) || (p == 1 && gnt1)) got = 1;
        end
        if (p == 0) req0 = 0; else req1 = 0;
        chk(p == 0 ? "port0_gnt_seen" : "port1_gnt_seen", 32'(got), 32'd1);
    endtask

    logic [DATA_W-1:0] old9;
    int                n_gnt0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 0;

        // Simultaneous stores: port 0 first, port 1 two cycles later.
        gnt_log.delete();
        fork
            drive(0, 1'b1, 6'd5, 16'h1234, 0);
            drive(1, 1'b1, 6'd6, 16'hBEEF, 0);
        join
        repeat (3) @(negedge clk);
        chk("st_gnt_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            chk("st_first_port", 32'(gnt_log[0].port), 32'd0);
            chk("st_second_port", 32'(gnt_log[1].port), 32'd1);
            chk("st_gnt_spacing", 32'(gnt_log[1].cyc - gnt_log[0].cyc), 32'd2);
        end
        chk("mem5", 32'(mem[5]), 32'h1234);
        chk("mem6", 32'(mem[6]), 32'hBEEF);

        // Port 1 load of address 6.
        drive(1, 1'b0, 6'd6, 16'h0, 0);
        chk("ld_mem_read_access", 32'(mem_read), 32'd1);
        @(negedge clk);
        chk("ld_rvalid1", 32'(rvalid1), 32'd1);
        chk("ld_rvalid0", 32'(rvalid0), 32'd0);
        chk("ld_rdata", 32'(rdata), 32'hBEEF);
        chk("ld_mem_read_resp", 32'(mem_read), 32'd0);
        repeat (2) @(negedge clk);
        chk("ld_rdata_hold", 32'(rdata), 32'hBEEF);

        // Both ports hammering loads: strict alternation, one grant per 3 cycles.
        gnt_log.delete();
        fork
            repeat (4) drive(0, 1'b0, ADDR_W'($urandom_range(0, 15)), 16'h0, 0);
            repeat (4) drive(1, 1'b0, ADDR_W'($urandom_range(0, 15)), 16'h0, 0);
        join
        repeat (3) @(negedge clk);
        chk("alt_gnt_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 1; i < gnt_log.size(); i++) begin
            chk("alt_port_changes", 32'(gnt_log[i].port != gnt_log[i-1].port), 32'd1);
            chk("alt_gnt_spacing", 32'(gnt_log[i].cyc - gnt_log[i-1].cyc), 32'd3);
        end

        // Asynchronous reset in the middle of a store's ACCESS cycle.
        old9 = mem[9];
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 6'd9; wdata0 = 16'h5555;
        @(negedge clk);
        chk("ar_gnt0", 32'(gnt0), 32'd1);
        chk("ar_mem_write_before", 32'(mem_write), 32'd1);
        #1 reset = 1;
        #1;
        chk("ar_mem_write_after", 32'(mem_write), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_gnt0_after", 32'(gnt0), 32'd0);
        req0 = 0;
        @(posedge clk);
        #1;
        chk("ar_mem9_unchanged", 32'(mem[9]), 32'(old9));
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("ar_no_retry", 32'(busy), 32'd0);
        chk("ar_mem9_final", 32'(mem[9]), 32'(old9));

        // req0 pulses only during RESP of a port 1 load: never sampled.
        drive(1, 1'b0, 6'd20, 16'h0, 0);
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 6'd3;
        n_gnt0 = 0;
        @(negedge clk);
        req0 = 0;
        for (int i = 0; i < 5; i++) begin
            if (gnt0) n_gnt0++;
            @(negedge clk);
        end
        chk("pulse_no_gnt0", 32'(n_gnt0), 32'd0);
        chk("pulse_idle", 32'(busy), 32'd0);

        // Randomized mixed traffic on both ports.
        fork
            for (int i = 0; i < 30; i++)
                drive(0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                      DATA_W'($urandom), $urandom_range(0, 3));
            for (int i = 0; i < 30; i++)
                drive(1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                      DATA_W'($urandom), $urandom_range(0, 3));
        join
        repeat (6) @(negedge clk);
        chk("end_gnt_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_rv_queue_empty", 32'(rv_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
